// File: rtl/priority_arbiter.sv
// Registered N-way arbiter with a held grant: fixed priority (highest index wins)
// or round-robin from a rotating pointer, selected by mode at each arbitration edge.
module priority_arbiter #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         done,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         valid,
    output logic         zero,
    output logic [0:0]   state
);

    localparam logic [0:0]   IDLE  = 1'b0;
    localparam logic [0:0]   GRANT = 1'b1;
    localparam logic [W-1:0] LAST  = W'(N - 1);
    localparam logic [W:0]   N_EXT = (W + 1)'(N);
    localparam logic [N-1:0] ONE   = N'(1);

    logic [W-1:0]   ptr;
    logic [N-1:0]   eligible;
    logic           release_now;
    logic           arb_edge;
    logic [W-1:0]   fixed_idx;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W-1:0]   rot_off;
    logic [W:0]     rr_sum;
    logic [W:0]     rr_diff;
    logic [W-1:0]   rr_idx;
    logic [W-1:0]   win_idx;
    logic [W-1:0]   next_ptr;
    logic [N-1:0]   win_onehot;

    always_comb begin
        // grant is all-zero in IDLE, so this masks out only the outgoing holder.
        eligible    = req & ~grant;
        release_now = (state == GRANT) && (done || !req[grant_idx]);
        arb_edge    = ((state == IDLE) || release_now) && (|eligible);

        fixed_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (eligible[i]) fixed_idx = W'(i);
        end

        // Rotate so the pointer position lands at bit 0, then take the lowest set bit.
        dbl     = {eligible, eligible} >> ptr;
        rot     = dbl[N-1:0];
        rot_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) rot_off = W'(i);
        end
        rr_sum  = {1'b0, ptr} + {1'b0, rot_off};
        rr_diff = rr_sum - N_EXT;
        rr_idx  = (rr_sum >= N_EXT) ? rr_diff[W-1:0] : rr_sum[W-1:0];

        win_idx    = mode ? rr_idx : fixed_idx;
        next_ptr   = (win_idx == LAST) ? '0 : win_idx + W'(1);
        win_onehot = ONE << win_idx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant     <= '0;
            grant_idx <= '0;
            valid     <= 1'b0;
            zero      <= 1'b1;
            ptr       <= '0;
            state     <= IDLE;
        end else begin
            zero <= ~|req;
            if (arb_edge) begin
                grant     <= win_onehot;
                grant_idx <= win_idx;
                valid     <= 1'b1;
                state     <= GRANT;
                if (mode) ptr <= next_ptr;
            end else if (release_now) begin
                grant     <= '0;
                grant_idx <= '0;
                valid     <= 1'b0;
                state     <= IDLE;
            end
        end
    end

endmodule

// File: doc/priority_arbiter.md
# priority_arbiter

Parametrised, registered N-way priority arbiter. It is the sequential successor to the 4-to-2 combinational priority encoder. It turns an N-bit request vector into a held one-hot grant plus binary index, and supports a runtime-selectable fixed-priority or round-robin mode. It sits in front of any shared resource (bus, port, FIFO write side) that several requesters contend for and that needs a grant held for a multi-cycle transaction.

## Interface
- `N`, default 8: number of requesters; legal range 2..64.
- `W` (localparam), value $clog2(N): width of the grant index.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `req`  in  N  request vector; bit i high = requester i wants the resource.
- `mode`  in  1  0 = fixed priority (highest index wins); 1 = round-robin.
- `done`  in  1  current grant holder releases the resource (one-cycle pulse).
- `grant`  out  N  registered one-hot grant, or all-zero.
- `grant_idx`  out  W  registered binary index of the granted bit; 0 when no grant.
- `valid`  out  1  registered; high while a grant is held.
- `zero`  out  1  registered; high when `req` sampled at the last edge was all-zero.

## Operation
Reset is synchronous and active-low: the reset is one clock and a synchronous, active-low `rst_n`. While `rst_n` = 0 at a rising edge:
- `grant` = 0, `grant_idx` = 0, `valid` = 0, `zero` = 1.
- Round-robin pointer `ptr` = 0; state = IDLE.

State machine (two states):
- IDLE: `valid` = 0. At an edge with `req` != 0, arbitrate, load `grant`/`grant_idx`, set `valid` = 1, go to GRANT. With `req` = 0, stay in IDLE.
- GRANT: hold `grant`/`grant_idx` unchanged. Release occurs at an edge where `done` = 1 or `req[grant_idx]` = 0.
  - On release, if any bit of `req` other than the outgoing holder is set, arbitrate among those bits in the same edge and stay in GRANT (back-to-back, no bubble).
  - Otherwise clear `grant`, set `grant_idx` = 0, `valid` = 0, and go to IDLE.
  - The outgoing holder is excluded from the back-to-back arbitration in both modes. It may win again only via IDLE or a later release.

Arbitration:
- `mode` = 0: the highest set index wins. `ptr` is not modified.
- `mode` = 1: the search starts at index `ptr` and moves upward with wrap-around (`ptr`, `ptr`+1, ..., N-1, 0, ..., `ptr`-1). The first set bit wins.
- On every grant taken in mode 1, `ptr` <= (winner + 1) mod N. Wrap: winner N-1 gives `ptr` = 0.

Other rules:
- `mode` is sampled only at arbitration edges. Changing it mid-grant does not disturb the current holder.
- `done` while in IDLE is ignored.
- `zero` <= ~|`req` every edge, independent of state.
- Invariants: `grant` is zero or exactly one-hot. `grant` != 0 if and only if `valid` = 1. `grant[grant_idx]` = 1 whenever `valid` = 1.

## Timing
- Request-to-grant latency is one edge. A `req` present before edge k produces `grant` visible after edge k.
- A release at edge k hands over to the next winner at the same edge k. Zero dead cycles between grants.
- A holder dropping `req` and asserting `done` in the same cycle counts as a single release.
- Simultaneous new requests at an arbitration edge are all considered in that edge. Late requests wait for the next arbitration.
- Reset mid-grant: the grant is dropped at that edge; `ptr` returns to 0.
- All outputs are registered; there is no combinational path from `req`, `mode` or `done` to any output.

## Test plan
All scenarios use N = 4.
- Reset: hold `rst_n` = 0 for 2 edges with `req` = 4'b1111 -> `grant` = 0, `grant_idx` = 0, `valid` = 0, `zero` = 1. After release, the first edge gives `grant` = 4'b1000, `valid` = 1.
- Fixed priority:
  - `mode` = 0, `req` = 4'b0110 -> `grant` = 4'b0100, `grant_idx` = 2.
  - Pulse `done` -> same edge `grant` = 4'b0010, `grant_idx` = 1.
  - Pulse `done` with `req` = 4'b0010 -> `grant` = 0, `valid` = 0.
- Round-robin fairness: `mode` = 1, `req` held at 4'b1111, `done` pulsed every 3rd cycle -> grants rotate 0, 1, 2, 3, 0. Each grant holds exactly 3 cycles and there are no idle cycles.
- Round-robin wrap and skip:
  - `ptr` = 3 (after granting 2), `req` = 4'b0101 -> `grant` = 4'b0001, then `ptr` = 1.
  - Next release with `req` = 4'b0101 -> `grant` = 4'b0100.
- Holder drop and mode switch:
  - The holder deasserts its `req` without `done` -> release at that edge.
  - Toggle `mode` mid-grant -> `grant` unchanged until release.
  - `zero` tracks `req` = 0 one edge later.
- Reset mid-grant: while `grant` = 4'b0100 in `mode` = 1, assert `rst_n` = 0 for one edge -> all outputs return to reset values. With `req` = 4'b1111 afterwards, the next grant is index 0.
